// File: rtl/uvmt_cv32e40s_sl_trigger_icount.sv
// Shadow model of icount (tdata1 type 3) debug triggers: tracks per-channel counts,
// fires when a count reaches zero, holds pending until debug entry, flags count divergence.
module uvmt_cv32e40s_sl_trigger_icount #(
    parameter int unsigned NUM_TRIGGERS = 4,
    parameter int unsigned COUNT_LSB    = 10,
    parameter int unsigned COUNT_W      = 14,
    localparam int unsigned IDX_W       = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 rvfi_valid_i,
    input  logic                                 rvfi_dbg_mode_i,
    input  logic                                 rvfi_exception_i,
    input  logic                                 is_mmode_i,
    input  logic                                 is_umode_i,
    input  logic [NUM_TRIGGERS-1:0][31:0]        tdata1_array_i,
    input  logic                                 tdata1_wr_i,
    input  logic [IDX_W-1:0]                     tdata1_wr_idx_i,
    input  logic [31:0]                          tdata1_wr_data_i,
    output logic [NUM_TRIGGERS-1:0]              icount_fire_o,
    output logic [NUM_TRIGGERS-1:0]              icount_pending_o,
    output logic [NUM_TRIGGERS-1:0][COUNT_W-1:0] model_count_o,
    output logic [NUM_TRIGGERS-1:0]              count_mismatch_o
);

    localparam logic [3:0] TYPE_ICOUNT = 4'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        PENDING  = 2'd2
    } state_e;

    state_e             state_q [NUM_TRIGGERS];
    state_e             state_d [NUM_TRIGGERS];
    logic [COUNT_W-1:0] count_q [NUM_TRIGGERS];
    logic [COUNT_W-1:0] count_d [NUM_TRIGGERS];

    logic [NUM_TRIGGERS-1:0] armed;
    logic [NUM_TRIGGERS-1:0] qual;
    logic [NUM_TRIGGERS-1:0] wr_hit;
    logic [NUM_TRIGGERS-1:0] wr_hit_q;
    logic [NUM_TRIGGERS-1:0] dec;
    logic [NUM_TRIGGERS-1:0] mismatch_d;
    logic [NUM_TRIGGERS-1:0] mismatch_q;
    logic                    wr_is_icount;
    logic [COUNT_W-1:0]      wr_count;

    // Only the type, mode and count fields of tdata1 matter here.
    logic unused_tdata1_bits;
    assign unused_tdata1_bits = ^{tdata1_array_i, tdata1_wr_data_i};

    assign wr_is_icount = (tdata1_wr_data_i[31:28] == TYPE_ICOUNT);
    assign wr_count     = tdata1_wr_data_i[COUNT_LSB +: COUNT_W];

    // Per-channel qualification of this cycle's retirement and CSR write.
    always_comb begin : qualify
        for (int t = 0; t < NUM_TRIGGERS; t++) begin
            armed[t]  = (tdata1_array_i[t][31:28] == TYPE_ICOUNT) &&
                        ((tdata1_array_i[t][9] && is_mmode_i) ||
                         (tdata1_array_i[t][6] && is_umode_i));
            qual[t]   = rvfi_valid_i && !rvfi_dbg_mode_i && !rvfi_exception_i && armed[t];
            wr_hit[t] = tdata1_wr_i && (tdata1_wr_idx_i == IDX_W'(t));
            dec[t]    = (state_q[t] == COUNTING) && qual[t] && !wr_hit[t] &&
                        (count_q[t] != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : state_reg
        if (rst_i) begin
            for (int t = 0; t < NUM_TRIGGERS; t++) begin
                state_q[t] <= IDLE;
                count_q[t] <= '0;
            end
            mismatch_q <= '0;
            wr_hit_q   <= '0;
        end else begin
            for (int t = 0; t < NUM_TRIGGERS; t++) begin
                state_q[t] <= state_d[t];
                count_q[t] <= count_d[t];
            end
            mismatch_q <= mismatch_d;
            wr_hit_q   <= wr_hit;
        end
    end

    // A CSR write overrides any same-cycle decrement on its channel.
    always_comb begin : next_state
        for (int t = 0; t < NUM_TRIGGERS; t++) begin
            state_d[t]    = state_q[t];
            count_d[t]    = count_q[t];
            mismatch_d[t] = armed[t] && !wr_hit_q[t] &&
                            (count_q[t] != tdata1_array_i[t][COUNT_LSB +: COUNT_W]);
            if (wr_hit[t]) begin
                count_d[t] = wr_is_icount ? wr_count : '0;
                state_d[t] = (wr_is_icount && (wr_count != '0)) ? COUNTING : IDLE;
            end else begin
                case (state_q[t])
                    COUNTING: begin
                        if (dec[t]) begin
                            count_d[t] = count_q[t] - COUNT_W'(1);
                            if (count_q[t] == COUNT_W'(1)) begin
                                state_d[t] = PENDING;
                            end
                        end
                    end
                    PENDING: begin
                        if (rvfi_valid_i && rvfi_dbg_mode_i) begin
                            state_d[t] = IDLE;
                        end
                    end
                    default: begin
                        state_d[t] = state_q[t];
                    end
                endcase
            end
        end
    end

    always_comb begin : outputs
        for (int t = 0; t < NUM_TRIGGERS; t++) begin
            icount_fire_o[t]    = dec[t] && (count_q[t] == COUNT_W'(1));
            icount_pending_o[t] = (state_q[t] == PENDING);
            model_count_o[t]    = count_q[t];
        end
    end

    assign count_mismatch_o = mismatch_q;

endmodule

// File: tb/tb_uvmt_cv32e40s_sl_trigger_icount.sv
// Bench for uvmt_cv32e40s_sl_trigger_icount: directed scenarios followed by random
// retirements and CSR writes, checked against a per-channel count/pending model.
module tb_uvmt_cv32e40s_sl_trigger_icount;

    localparam int unsigned NT = 4;
    localparam int unsigned CL = 10;
    localparam int unsigned CW = 14;

    logic clk = 1'b0;
    logic rst;
    logic valid, dbg, exc, mm, um, wr;
    logic [1:0]             wr_idx;
    logic [31:0]            wr_data;
    logic [NT-1:0][31:0]    tdata1_array;
    logic [NT-1:0]          fire, pending, mismatch;
    logic [NT-1:0][CW-1:0]  mcount;
    logic [NT-1:0]          last_fire;

    int m_cnt    [NT];
    bit m_pend   [NT];
    bit m_mis    [NT];
    bit m_wrprev [NT];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uvmt_cv32e40s_sl_trigger_icount #(
        .NUM_TRIGGERS (NT),
        .COUNT_LSB    (CL),
        .COUNT_W      (CW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .rvfi_valid_i     (valid),
        .rvfi_dbg_mode_i  (dbg),
        .rvfi_exception_i (exc),
        .is_mmode_i       (mm),
        .is_umode_i       (um),
        .tdata1_array_i   (tdata1_array),
        .tdata1_wr_i      (wr),
        .tdata1_wr_idx_i  (wr_idx),
        .tdata1_wr_data_i (wr_data),
        .icount_fire_o    (fire),
        .icount_pending_o (pending),
        .model_count_o    (mcount),
        .count_mismatch_o (mismatch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fld(input logic [31:0] d);
        return int'(d[CL +: CW]);
    endfunction

    function automatic bit is_armed(input int t);
        logic [31:0] d;
        d = tdata1_array[t];
        return (d[31:28] == 4'd3) && ((d[9] && mm) || (d[6] && um));
    endfunction

    function automatic logic [31:0] icnt(input int count, input bit m, input bit u);
        logic [31:0] d;
        d = 32'h3000_0000;
        d[CL +: CW] = CW'(count);
        d[9] = m;
        d[6] = u;
        return d;
    endfunction

    task automatic clr_in();
        valid = 0; dbg = 0; exc = 0; mm = 0; um = 0;
        wr = 0; wr_idx = 0; wr_data = 0;
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_cnt[t] = 0; m_pend[t] = 0; m_mis[t] = 0; m_wrprev[t] = 0;
        end
    endtask

    // One clock: check the combinational fire before the edge, registered state after.
    task automatic step(input string tag);
        logic [NT-1:0] e_fire, e_pend, e_mis;
        bit qual, wr_t, arm;
        for (int t = 0; t < NT; t++) begin
            arm  = is_armed(t);
            qual = valid && !dbg && !exc && arm;
            wr_t = wr && (int'(wr_idx) == t);
            e_fire[t] = qual && !wr_t && !m_pend[t] && (m_cnt[t] == 1);
        end
        #3;
        last_fire = fire;
        chk({tag, "_fire"}, 32'(fire), 32'(e_fire));
        @(posedge clk);
        #1;
        for (int t = 0; t < NT; t++) begin
            arm  = is_armed(t);
            qual = valid && !dbg && !exc && arm;
            wr_t = wr && (int'(wr_idx) == t);
            m_mis[t] = arm && !m_wrprev[t] && (m_cnt[t] != fld(tdata1_array[t]));
            if (wr_t) begin
                m_cnt[t]  = (wr_data[31:28] == 4'd3) ? fld(wr_data) : 0;
                m_pend[t] = 0;
            end else if (m_pend[t]) begin
                if (valid && dbg) m_pend[t] = 0;
            end else if (qual && m_cnt[t] > 0) begin
                m_cnt[t]--;
                if (m_cnt[t] == 0) m_pend[t] = 1;
            end
            m_wrprev[t] = wr_t;
            e_pend[t] = m_pend[t];
            e_mis[t]  = m_mis[t];
        end
        chk({tag, "_pending"}, 32'(pending), 32'(e_pend));
        chk({tag, "_mismatch"}, 32'(mismatch), 32'(e_mis));
        for (int t = 0; t < NT; t++) begin
            chk($sformatf("%s_count%0d", tag, t), 32'(mcount[t]), 32'(m_cnt[t]));
        end
    endtask

    task automatic wr_ch(input int idx, input logic [31:0] d, input string tag);
        clr_in();
        wr = 1; wr_idx = 2'(idx); wr_data = d;
        tdata1_array[idx] = d;
        step(tag);
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_fire"}, 32'(fire), 32'h0);
        chk({tag, "_pending"}, 32'(pending), 32'h0);
        chk({tag, "_mismatch"}, 32'(mismatch), 32'h0);
        chk({tag, "_count_zero"}, 32'(mcount == '0), 32'h1);
    endtask

    initial begin
        rst = 1;
        clr_in();
        tdata1_array = '0;
        last_fire = '0;
        model_reset();
        #2;
        check_reset_zero("por");
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Count of 2, M-mode: fires on the second retirement, pending until debug entry
        wr_ch(0, 32'h3000_0A00, "t1_wr");
        clr_in(); valid = 1; mm = 1; step("t1_r1");
        chk("t1_r1_nofire", 32'(last_fire[0]), 32'h0);
        step("t1_r2");
        chk("t1_r2_fire", 32'(last_fire[0]), 32'h1);
        chk("t1_count0", 32'(mcount[0]), 32'h0);
        chk("t1_pend", 32'(pending[0]), 32'h1);
        clr_in(); valid = 1; dbg = 1; step("t1_dbg");
        chk("t1_pend_clr", 32'(pending[0]), 32'h0);

        // U-only trigger ignores M-mode retirements
        wr_ch(1, icnt(1, 0, 1), "t2_wr");
        for (int i = 0; i < 3; i++) begin
            clr_in(); valid = 1; mm = 1; step("t2_m");
            chk("t2_m_nofire", 32'(last_fire[1]), 32'h0);
        end
        chk("t2_count1", 32'(mcount[1]), 32'h1);
        clr_in(); valid = 1; um = 1; step("t2_u");
        chk("t2_u_fire", 32'(last_fire[1]), 32'h1);

        // Write wins over a same-cycle final decrement
        wr_ch(2, icnt(1, 1, 0), "t3_wr1");
        clr_in(); valid = 1; mm = 1; wr = 1; wr_idx = 2; wr_data = icnt(5, 1, 0);
        step("t3_both");
        chk("t3_nofire", 32'(last_fire[2]), 32'h0);
        chk("t3_count5", 32'(mcount[2]), 32'h5);

        // Excepting retirement does not count
        wr_ch(3, icnt(1, 1, 0), "t4_wr");
        clr_in(); valid = 1; mm = 1; exc = 1; step("t4_exc");
        chk("t4_exc_nofire", 32'(last_fire[3]), 32'h0);
        chk("t4_exc_count", 32'(mcount[3]), 32'h1);
        clr_in(); valid = 1; mm = 1; step("t4_clean");
        chk("t4_fire", 32'(last_fire[3]), 32'h1);

        // DUT count field diverges from the shadow count
        wr_ch(2, icnt(2, 1, 0), "t5_wr");
        clr_in(); mm = 1; step("t5_settle");
        tdata1_array[2] = icnt(3, 1, 0);
        clr_in(); mm = 1; step("t5_div");
        chk("t5_mismatch", 32'(mismatch[2]), 32'h1);
        chk("t5_count2", 32'(mcount[2]), 32'h2);

        // Async reset while every channel is pending
        for (int t = 0; t < NT; t++) wr_ch(t, icnt(1, 1, 0), "t6_wr");
        clr_in(); valid = 1; mm = 1; step("t6_fire");
        chk("t6_fire_all", 32'(last_fire), 32'hF);
        chk("t6_pend_all", 32'(pending), 32'hF);
        clr_in();
        rst = 1;
        #1;
        check_reset_zero("t6_rst");
        model_reset();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        clr_in(); valid = 1; mm = 1; step("t6_post");
        chk("t6_post_nofire", 32'(last_fire), 32'h0);

        // Random retirements and writes against the model
        for (int i = 0; i < 400; i++) begin
            clr_in();
            valid = ($urandom_range(0, 9) < 7);
            dbg   = ($urandom_range(0, 9) == 0);
            exc   = ($urandom_range(0, 9) == 0);
            mm    = 1'($urandom);
            um    = !mm;
            if ($urandom_range(0, 5) == 0) begin
                wr      = 1;
                wr_idx  = 2'($urandom_range(0, NT - 1));
                wr_data = icnt($urandom_range(0, 4), 1'($urandom), 1'($urandom));
                if ($urandom_range(0, 5) == 0) wr_data[31:28] = 4'($urandom_range(4, 15));
                if ($urandom_range(0, 1) == 0) tdata1_array[wr_idx] = wr_data;
            end
            if ($urandom_range(0, 15) == 0) begin
                tdata1_array[$urandom_range(0, NT - 1)] =
                    icnt($urandom_range(0, 4), 1'($urandom), 1'($urandom));
            end
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
